// File: rtl/jb_ul_dfe_ant_s2p_dmx.sv
// Serial-to-parallel antenna demux for the UL DFE.
// Rebuilds one frame of N_ANTENNAS time-interleaved samples (tuser = antenna index) and
// strobes all antennas together. Checks index sequencing and the gap timeout inside a frame.
module jb_ul_dfe_ant_s2p_dmx #(
   parameter int unsigned N_ANTENNAS = 4,
   parameter int unsigned PRECISION  = 16,
   parameter int unsigned USR_ID_BW  = 2,
   parameter int unsigned MAX_GAP    = 3,
   parameter int unsigned CNT_BW     = 16
) (
   input  logic                   clk_4x,
   input  logic                   resetn_4x,
   input  logic                   any_stream_enable,
   input  logic                   tvalid_in,
   input  logic [2*PRECISION-1:0] tdata_in,
   input  logic [USR_ID_BW-1:0]   tuser_in,
   output logic [N_ANTENNAS-1:0]  tvalid_out,
   output logic [2*PRECISION-1:0] tdata_out [N_ANTENNAS-1:0],
   output logic [CNT_BW-1:0]      frame_cnt,
   output logic                   seq_err,
   input  logic                   clr_err
);

   localparam int unsigned SW = 2 * PRECISION;
   localparam int unsigned GW = $clog2(MAX_GAP + 2);
   localparam logic [USR_ID_BW-1:0] LastIdx = USR_ID_BW'(N_ANTENNAS - 1);
   localparam logic [GW-1:0]        GapMax  = GW'(MAX_GAP);

   typedef enum logic {StHunt, StCollect} state_e;

   state_e               state_q;
   logic [USR_ID_BW-1:0] exp_q;
   logic [GW-1:0]        gap_q;
   logic [SW-1:0]        stage_q [N_ANTENNAS-2:0];

   // Frame assembly FSM with registered outputs; clr_err is applied first so a set wins.
   always_ff @(posedge clk_4x) begin
      if (!resetn_4x) begin
         state_q    <= StHunt;
         exp_q      <= '0;
         gap_q      <= '0;
         tvalid_out <= '0;
         frame_cnt  <= '0;
         seq_err    <= 1'b0;
         for (int k = 0; k < int'(N_ANTENNAS) - 1; k++) stage_q[k] <= '0;
         for (int k = 0; k < int'(N_ANTENNAS); k++) tdata_out[k] <= '0;
      end else begin
         tvalid_out <= '0;
         if (clr_err) seq_err <= 1'b0;

         if (!any_stream_enable) begin
            // Flush and hunt; a frame completing now is not emitted.
            state_q <= StHunt;
            exp_q   <= '0;
            gap_q   <= '0;
         end else if (state_q == StHunt) begin
            gap_q <= '0;
            if (tvalid_in && tuser_in == '0) begin
               stage_q[0] <= tdata_in;
               exp_q      <= USR_ID_BW'(1);
               state_q    <= StCollect;
            end
         end else if (tvalid_in) begin
            gap_q <= '0;
            if (tuser_in == exp_q) begin
               if (exp_q == LastIdx) begin
                  for (int k = 0; k < int'(N_ANTENNAS) - 1; k++) tdata_out[k] <= stage_q[k];
                  tdata_out[N_ANTENNAS-1] <= tdata_in;
                  tvalid_out <= '1;
                  frame_cnt  <= frame_cnt + CNT_BW'(1);
                  exp_q      <= '0;
               end else begin
                  for (int k = 0; k < int'(N_ANTENNAS) - 1; k++) begin
                     if (exp_q == USR_ID_BW'(k)) stage_q[k] <= tdata_in;
                  end
                  exp_q <= exp_q + USR_ID_BW'(1);
               end
            end else begin
               // Out-of-order index: drop partial frame, restart directly on a slot-0 sample.
               seq_err <= 1'b1;
               if (tuser_in == '0) begin
                  stage_q[0] <= tdata_in;
                  exp_q      <= USR_ID_BW'(1);
               end else begin
                  exp_q   <= '0;
                  state_q <= StHunt;
               end
            end
         end else if (exp_q != '0) begin
            // Idle inside a partial frame; the (MAX_GAP+1)-th idle cycle times out.
            if (gap_q == GapMax) begin
               seq_err <= 1'b1;
               exp_q   <= '0;
               gap_q   <= '0;
               state_q <= StHunt;
            end else begin
               gap_q <= gap_q + GW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_jb_ul_dfe_ant_s2p_dmx.sv
// Scoreboard bench for jb_ul_dfe_ant_s2p_dmx: stimulus pushes expected frames,
// a negedge monitor pops and compares on every strobe.
module tb_jb_ul_dfe_ant_s2p_dmx;

   logic        clk_4x = 1'b0;
   logic        resetn_4x;
   logic        any_stream_enable;
   logic        tvalid_in;
   logic [31:0] tdata_in;
   logic [1:0]  tuser_in;
   logic [3:0]  tvalid_out;
   logic [31:0] tdata_out [3:0];
   logic [15:0] frame_cnt;
   logic        seq_err;
   logic        clr_err;

   typedef struct packed {
      logic [3:0][31:0] d;
      logic [15:0]      cnt;
      int unsigned      e;
   } exp_t;

   exp_t        sb_q [$];
   int unsigned edge_n = 0;
   int          n_chk  = 0;
   int          n_pass = 0;

   jb_ul_dfe_ant_s2p_dmx dut (
      .clk_4x            (clk_4x),
      .resetn_4x         (resetn_4x),
      .any_stream_enable (any_stream_enable),
      .tvalid_in         (tvalid_in),
      .tdata_in          (tdata_in),
      .tuser_in          (tuser_in),
      .tvalid_out        (tvalid_out),
      .tdata_out         (tdata_out),
      .frame_cnt         (frame_cnt),
      .seq_err           (seq_err),
      .clr_err           (clr_err)
   );

   always #5 clk_4x = ~clk_4x;

   always @(posedge clk_4x) edge_n = edge_n + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, got, want);
   endtask

   // Monitor: every strobe must match the oldest expected frame, on its expected edge.
   always @(negedge clk_4x) begin
      while (sb_q.size() > 0 && sb_q[0].e < edge_n) begin
         chk("missed_strobe_edge", 64'(edge_n), 64'(sb_q[0].e));
         void'(sb_q.pop_front());
      end
      if (tvalid_out != 4'b0000) begin
         chk("tvalid_all_bits", 64'(tvalid_out), 64'hf);
         if (sb_q.size() == 0) begin
            chk("unexpected_strobe", 64'(tvalid_out), 64'h0);
         end else begin
            chk("strobe_edge", 64'(edge_n), 64'(sb_q[0].e));
            for (int k = 0; k < 4; k++) chk($sformatf("tdata_out[%0d]", k),
                                            64'(tdata_out[k]), 64'(sb_q[0].d[k]));
            chk("frame_cnt_at_strobe", 64'(frame_cnt), 64'(sb_q[0].cnt));
            void'(sb_q.pop_front());
         end
      end
   end

   // One cycle of stimulus; input is captured on the next rising edge.
   task automatic smp(input logic [1:0] u, input logic [31:0] d);
      tvalid_in = 1'b1;
      tuser_in  = u;
      tdata_in  = d;
      @(posedge clk_4x);
      #1;
      tvalid_in = 1'b0;
      tuser_in  = 2'd0;
      tdata_in  = 32'h0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_4x);
         #1;
      end
   endtask

   // Call just before the slot-3 sample: strobe is due on that capture edge.
   task automatic expect_frame(input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [15:0] cnt);
      exp_t x;
      x.d   = {d3, d2, d1, d0};
      x.cnt = cnt;
      x.e   = edge_n + 1;
      sb_q.push_back(x);
   endtask

   initial begin
      resetn_4x         = 1'b0;
      any_stream_enable = 1'b1;
      tvalid_in         = 1'b0;
      tdata_in          = 32'h0;
      tuser_in          = 2'd0;
      clr_err           = 1'b0;
      idle(2);
      resetn_4x = 1'b1;
      chk("reset_tvalid_out", 64'(tvalid_out), 64'h0);
      chk("reset_frame_cnt", 64'(frame_cnt), 64'h0);
      chk("reset_seq_err", 64'(seq_err), 64'h0);
      for (int k = 0; k < 4; k++) chk("reset_tdata_out", 64'(tdata_out[k]), 64'h0);

      // T1 nominal, three back-to-back frames
      smp(2'd0, 32'h1000); smp(2'd1, 32'h1001); smp(2'd2, 32'h1002);
      expect_frame(32'h1000, 32'h1001, 32'h1002, 32'h1003, 16'd1);
      smp(2'd3, 32'h1003);
      smp(2'd0, 32'h2000); smp(2'd1, 32'h2001); smp(2'd2, 32'h2002);
      expect_frame(32'h2000, 32'h2001, 32'h2002, 32'h2003, 16'd2);
      smp(2'd3, 32'h2003);
      smp(2'd0, 32'h3000); smp(2'd1, 32'h3001); smp(2'd2, 32'h3002);
      expect_frame(32'h3000, 32'h3001, 32'h3002, 32'h3003, 16'd3);
      smp(2'd3, 32'h3003);
      idle(5);
      chk("t1_frame_cnt", 64'(frame_cnt), 64'd3);
      chk("t1_seq_err", 64'(seq_err), 64'h0);
      chk("t1_hold_tdata0", 64'(tdata_out[0]), 64'h3000);
      chk("t1_hold_tdata3", 64'(tdata_out[3]), 64'h3003);

      // Back to HUNT without error
      any_stream_enable = 1'b0;
      idle(1);
      any_stream_enable = 1'b1;

      // T2 mid-frame start
      smp(2'd2, 32'h4f02); smp(2'd3, 32'h4f03);
      smp(2'd0, 32'h4000); smp(2'd1, 32'h4001); smp(2'd2, 32'h4002);
      expect_frame(32'h4000, 32'h4001, 32'h4002, 32'h4003, 16'd4);
      smp(2'd3, 32'h4003);
      idle(2);
      chk("t2_seq_err", 64'(seq_err), 64'h0);
      chk("t2_frame_cnt", 64'(frame_cnt), 64'd4);

      // T3 sequence break, recovery, clear, set-beats-clear
      smp(2'd0, 32'h5f00); smp(2'd1, 32'h5f01); smp(2'd3, 32'h5f03);
      chk("t3_seq_err_set", 64'(seq_err), 64'h1);
      smp(2'd0, 32'h5000); smp(2'd1, 32'h5001); smp(2'd2, 32'h5002);
      expect_frame(32'h5000, 32'h5001, 32'h5002, 32'h5003, 16'd5);
      smp(2'd3, 32'h5003);
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      chk("t3_seq_err_cleared", 64'(seq_err), 64'h0);
      clr_err = 1'b1;
      smp(2'd2, 32'h5e02);
      clr_err = 1'b0;
      chk("t3_set_wins", 64'(seq_err), 64'h1);
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;

      // T4 gap of MAX_GAP is tolerated, MAX_GAP+1 times out
      smp(2'd0, 32'h6000); smp(2'd1, 32'h6001);
      idle(3);
      smp(2'd2, 32'h6002);
      expect_frame(32'h6000, 32'h6001, 32'h6002, 32'h6003, 16'd6);
      smp(2'd3, 32'h6003);
      idle(1);
      chk("t4_gap3_no_err", 64'(seq_err), 64'h0);
      smp(2'd0, 32'h6100); smp(2'd1, 32'h6101);
      idle(4);
      chk("t4_gap4_err", 64'(seq_err), 64'h1);
      smp(2'd2, 32'h6102); smp(2'd3, 32'h6103);
      idle(1);
      chk("t4_no_strobe_cnt", 64'(frame_cnt), 64'd6);
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;

      // T5 enable drop mid-frame, and last sample while disabled
      smp(2'd0, 32'h7000); smp(2'd1, 32'h7001);
      any_stream_enable = 1'b0;
      idle(1);
      any_stream_enable = 1'b1;
      smp(2'd0, 32'h8000); smp(2'd1, 32'h8001); smp(2'd2, 32'h8002);
      expect_frame(32'h8000, 32'h8001, 32'h8002, 32'h8003, 16'd7);
      smp(2'd3, 32'h8003);
      smp(2'd0, 32'h8800); smp(2'd1, 32'h8801); smp(2'd2, 32'h8802);
      any_stream_enable = 1'b0;
      smp(2'd3, 32'h8803);
      any_stream_enable = 1'b1;
      idle(2);
      chk("t5_seq_err", 64'(seq_err), 64'h0);
      chk("t5_frame_cnt", 64'(frame_cnt), 64'd7);

      // T6 reset mid-frame
      smp(2'd0, 32'h9000); smp(2'd1, 32'h9001); smp(2'd2, 32'h9002);
      resetn_4x = 1'b0;
      idle(1);
      resetn_4x = 1'b1;
      chk("t6_tvalid_out", 64'(tvalid_out), 64'h0);
      chk("t6_frame_cnt", 64'(frame_cnt), 64'h0);
      chk("t6_seq_err", 64'(seq_err), 64'h0);
      chk("t6_tdata0", 64'(tdata_out[0]), 64'h0);
      chk("t6_tdata3", 64'(tdata_out[3]), 64'h0);
      smp(2'd3, 32'ha0f3);
      smp(2'd0, 32'ha000); smp(2'd1, 32'ha001); smp(2'd2, 32'ha002);
      expect_frame(32'ha000, 32'ha001, 32'ha002, 32'ha003, 16'd1);
      smp(2'd3, 32'ha003);
      idle(1);
      chk("t6_frame_cnt_after", 64'(frame_cnt), 64'd1);

      // T7 restart on slot 0 inside a partial frame
      smp(2'd0, 32'hb000); smp(2'd1, 32'hb001);
      smp(2'd0, 32'hc000); smp(2'd1, 32'hc001); smp(2'd2, 32'hc002);
      expect_frame(32'hc000, 32'hc001, 32'hc002, 32'hc003, 16'd2);
      smp(2'd3, 32'hc003);
      idle(3);
      chk("t7_seq_err", 64'(seq_err), 64'h1);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
